normalize_sequencer: RTL
========================

Name: normalize_sequencer

Overview:
- Multi-cycle post-add normalizer for the fixed/floating-point adder datapath.
- Accepts a raw sum (mantissa plus possible carry bit, and an exponent) over a valid/ready handshake.
- Locates the leading one with one internal FindFirstOne instance (N=32), then normalizes through a bounded-step shifter over several cycles, adjusting the exponent.
- Flags zero, underflow (denormal result) and overflow; sits between the mantissa adder and the result packer.

Parameters:
MANT_W, 24, mantissa width including hidden bit; input is MANT_W+1 bits (bit MANT_W = carry)
EXP_W, 8, biased exponent width
MAX_SHIFT, 4, maximum left-shift distance applied per SHIFT cycle (1..MANT_W-1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input sum valid
in_ready  output  1  block can accept input
in_mant  input  MANT_W+1  raw mantissa sum, bit MANT_W is carry-out
in_exp  input  EXP_W  biased exponent of sum
out_valid  output  1  normalized result valid
out_ready  input  1  downstream accepts result
out_mant  output  MANT_W  normalized mantissa, hidden bit at MANT_W-1
out_exp  output  EXP_W  adjusted biased exponent
out_zero  output  1  input mantissa was zero
out_underflow  output  1  result denormal (exponent exhausted during shift)
out_overflow  output  1  carry normalization reached exponent all-ones

Behaviour:
- Reset (rst_n low, async): state IDLE; out_valid, out_mant, out_exp and all flags = 0; internal regs cleared. in_ready = 1 in IDLE. Reset mid-operation discards the in-flight result.
- FSM states: IDLE, EVAL, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid capture in_mant->M, in_exp->E and go to EVAL. in_ready=0 in every other state.
- EVAL (1 cycle): FFO on zero-extended M gives idx.
  - M==0: mant=0, exp=0, zero=1; go to DONE.
  - idx==MANT_W (carry): M>>=1 (LSB truncated), E+=1. If the new E is all-ones: mant=0, overflow=1. Go to DONE.
  - idx==MANT_W-1: already normalized; go to DONE.
  - Otherwise s = MANT_W-1-idx.
    - If E > s: R = s, final exp E-s, no flag.
    - If E <= s: R = max(E-1,0), final exp 0, underflow=1.
    - R==0 goes to DONE; else go to SHIFT.
- SHIFT: each cycle step = min(R, MAX_SHIFT); M<<=step, E-=step, R-=step. When R reaches 0, go to DONE; in the underflow case E is forced to 0 on that transition.
- DONE: out_valid=1, outputs stable. Hold until out_ready is sampled high, then clear out_valid and go to IDLE. No new acceptance in the same cycle (max throughput: one result per accept-to-accept interval).
- Latency: accept at edge k; out_valid high from edge k+2+ceil(R/MAX_SHIFT).
- Outputs are registered and only change on entry to DONE or on reset. Flags are mutually exclusive.
- Exponent arithmetic is unsigned EXP_W wide and must never wrap: underflow and overflow rules above take precedence.

Test Plan:
- in_mant=0x0800000, in_exp=100 -> out_valid at accept+2, out_mant=0x800000, out_exp=100, all flags 0.
- in_mant=0x1800001, in_exp=100 -> out_mant=0xC00000, out_exp=101. Same mant with in_exp=254 -> out_exp=255, out_mant=0, out_overflow=1.
- in_mant=0x0000001, in_exp=100, MAX_SHIFT=4 -> 6 SHIFT cycles, out_valid at accept+8, out_mant=0x800000, out_exp=77.
- in_mant=0x0000100, in_exp=10 -> shift 9, out_mant=0x020000, out_exp=0, out_underflow=1. in_mant=0 -> out_zero=1, mant=0, exp=0 at accept+2.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs and out_valid stable, in_ready=0. Assert in_valid during that time -> not accepted. Accepted on the first IDLE cycle.
- Reset: drive rst_n low mid-SHIFT -> out_valid=0, outputs 0 immediately. After release, in_ready=1 and the next transaction is correct.

Source files
------------

// File: rtl/normalize_sequencer.sv
// Post-add normalizer: finds the leading one of a raw sum and left/right shifts it
// into hidden-bit position over several cycles, tracking the exponent and range flags.

module find_first_one #(
  parameter int N  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Highest set bit wins: later iterations overwrite lower positions.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx   = vec[i] ? IW'(i) : idx;
      found = found | vec[i];
    end
  end

endmodule

module normalize_sequencer #(
  parameter int MANT_W    = 24,
  parameter int EXP_W     = 8,
  parameter int MAX_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W:0]   in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_underflow,
  output logic              out_overflow
);

  localparam int FFO_N = 32;
  localparam int IW    = $clog2(FFO_N);
  localparam int RW    = $clog2(MANT_W + 1);
  localparam int DW    = ((EXP_W > RW) ? EXP_W : RW) + 1;
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r, state_nx_s;
  logic [MANT_W:0]   m_r;
  logic [EXP_W-1:0]  e_r;
  logic [RW-1:0]     r_r;
  logic              zero_r, uf_r, ovf_r;
  logic              in_ready_r;

  logic [FFO_N-1:0]  ffo_vec_s;
  logic [IW-1:0]     idx_s;
  logic              found_s;
  logic [RW-1:0]     s_s;
  logic              carry_s, norm_s;

  logic [MANT_W:0]   eval_m_s;
  logic [EXP_W-1:0]  eval_e_s;
  logic [RW-1:0]     eval_r_s;
  logic              eval_zero_s, eval_uf_s, eval_ovf_s;
  logic [RW-1:0]     step_s;

  assign ffo_vec_s = {{(FFO_N-MANT_W-1){1'b0}}, m_r};

  find_first_one #(.N(FFO_N), .IW(IW)) u_ffo (
    .vec   (ffo_vec_s),
    .idx   (idx_s),
    .found (found_s)
  );

  assign carry_s  = found_s && (idx_s == IW'(MANT_W));
  assign norm_s   = found_s && (idx_s == IW'(MANT_W - 1));
  assign s_s      = RW'(MANT_W - 1) - RW'(idx_s);
  assign step_s   = (r_r > RW'(MAX_SHIFT)) ? RW'(MAX_SHIFT) : r_r;
  assign in_ready = in_ready_r;

  // Classify the captured sum and choose the shift plan; exponent saturates instead of wrapping.
  always_comb begin
    eval_m_s    = m_r;
    eval_e_s    = e_r;
    eval_r_s    = '0;
    eval_zero_s = 1'b0;
    eval_uf_s   = 1'b0;
    eval_ovf_s  = 1'b0;
    if (!found_s) begin
      eval_m_s    = '0;
      eval_e_s    = '0;
      eval_zero_s = 1'b1;
    end else if (carry_s) begin
      if (e_r >= EXP_MAX - EXP_W'(1)) begin
        eval_m_s   = '0;
        eval_e_s   = EXP_MAX;
        eval_ovf_s = 1'b1;
      end else begin
        eval_m_s = m_r >> 1;
        eval_e_s = e_r + EXP_W'(1);
      end
    end else if (norm_s) begin
      eval_m_s = m_r;
    end else if (DW'(e_r) > DW'(s_s)) begin
      eval_r_s = s_s;
    end else begin
      // Shift only until the exponent reaches 1, then report it as 0 (denormal).
      eval_r_s  = (e_r == '0) ? '0 : RW'(e_r - EXP_W'(1));
      eval_uf_s = 1'b1;
      eval_e_s  = (e_r <= EXP_W'(1)) ? '0 : e_r;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nx_s = EVAL;
        else          state_nx_s = IDLE;
      end
      EVAL: begin
        if (eval_zero_s || eval_ovf_s || carry_s || norm_s || (eval_r_s == '0)) state_nx_s = DONE;
        else                                                                     state_nx_s = SHIFT;
      end
      SHIFT: begin
        if (r_r <= RW'(MAX_SHIFT)) state_nx_s = DONE;
        else                       state_nx_s = SHIFT;
      end
      DONE: begin
        if (out_valid && out_ready) state_nx_s = IDLE;
        else                        state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nx_s;
      in_ready_r <= (state_nx_s == IDLE);
    end
  end

  // Working datapath and output registers; outputs load once on the first DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r           <= '0;
      e_r           <= '0;
      r_r           <= '0;
      zero_r        <= 1'b0;
      uf_r          <= 1'b0;
      ovf_r         <= 1'b0;
      out_valid     <= 1'b0;
      out_mant      <= '0;
      out_exp       <= '0;
      out_zero      <= 1'b0;
      out_underflow <= 1'b0;
      out_overflow  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            m_r    <= in_mant;
            e_r    <= in_exp;
            r_r    <= '0;
            zero_r <= 1'b0;
            uf_r   <= 1'b0;
            ovf_r  <= 1'b0;
          end
        end
        EVAL: begin
          m_r    <= eval_m_s;
          e_r    <= eval_e_s;
          r_r    <= eval_r_s;
          zero_r <= eval_zero_s;
          uf_r   <= eval_uf_s;
          ovf_r  <= eval_ovf_s;
        end
        SHIFT: begin
          m_r <= m_r << step_s;
          r_r <= r_r - step_s;
          if (uf_r && (r_r == step_s)) e_r <= '0;
          else                         e_r <= e_r - EXP_W'(step_s);
        end
        DONE: begin
          if (!out_valid) begin
            out_valid     <= 1'b1;
            out_mant      <= m_r[MANT_W-1:0];
            out_exp       <= e_r;
            out_zero      <= zero_r;
            out_underflow <= uf_r;
            out_overflow  <= ovf_r;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
